// File: rtl/axi4lite_reg_ctrl_if.sv
// AXI4-Lite slave bus bundle for axi4lite_reg_ctrl.
//
// Purpose : groups the five AXI4-Lite channels (AW, W, B, AR, R) into one
//           connection. The modports give the direction for each side.
// Signals : s_axi_aw*  write address channel  (addr, valid, ready)
//           s_axi_w*   write data channel     (data, strb, valid, ready)
//           s_axi_b*   write response channel (resp, valid, ready)
//           s_axi_ar*  read address channel   (addr, valid, ready)
//           s_axi_r*   read data channel      (data, resp, valid, ready)
// The ADDR_WIDTH parameter must match the controller's byte address width,
// which is $clog2(NUM_REGS)+2.
interface axi4lite_reg_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [31:0]           s_axi_wdata;
  logic [3:0]            s_axi_wstrb;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [31:0]           s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axi4lite_reg_ctrl.sv
// AXI4-Lite register-bank controller.
//
// Purpose : serves NUM_REGS 32-bit registers over an AXI4-Lite slave port.
//           Writes are turned into a one-cycle one-hot strobe towards the
//           register bank; reads sample the flattened register contents.
//           One transaction is in flight at a time; reads and writes that
//           contend in the same cycle are granted alternately.
// Ports   : clk          single clock, rising edge
//           rst          asynchronous active-high reset
//           s_axi        AXI4-Lite slave modport (see axi4lite_reg_ctrl_if)
//           reg_wr_en    one-hot write strobe, one cycle per in-range write
//           reg_wr_data  write data, valid while reg_wr_en is nonzero
//           reg_wr_strb  byte strobes, valid while reg_wr_en is nonzero
//           reg_rd_data  register contents, register i at [32*i+31:32*i]
module axi4lite_reg_ctrl #(
  parameter int NUM_REGS = 4,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS) + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  axi4lite_reg_ctrl_if.slave       s_axi,
  output logic [NUM_REGS-1:0]      reg_wr_en,
  output logic [31:0]              reg_wr_data,
  output logic [3:0]               reg_wr_strb,
  input  logic [NUM_REGS*32-1:0]   reg_rd_data
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] REG_COUNT = ADDR_WIDTH'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_RESP = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  state_t state;
  // 1: the last granted transaction was a write; resets to "read" so the
  // first write/read tie goes to the write.
  logic   last_grant_wr;

  logic [ADDR_WIDTH-1:0] wr_word;
  logic [ADDR_WIDTH-1:0] rd_word;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_cand;
  logic                  rd_cand;
  logic                  grant_wr;
  logic                  grant_rd;

  function automatic logic [NUM_REGS-1:0] decode_onehot(
    input logic [ADDR_WIDTH-1:0] word
  );
    logic [NUM_REGS-1:0] en;
    en = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (word == ADDR_WIDTH'(i)) en[i] = 1'b1;
    end
    return en;
  endfunction

  // Out-of-range words match no register and return zero.
  function automatic logic [31:0] select_reg(
    input logic [NUM_REGS*32-1:0] regs,
    input logic [ADDR_WIDTH-1:0]  word
  );
    logic [31:0] data;
    data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (word == ADDR_WIDTH'(i)) data = regs[32*i +: 32];
    end
    return data;
  endfunction

  function automatic logic [1:0] resp_code(input logic in_range);
    return in_range ? RESP_OKAY : RESP_SLVERR;
  endfunction

  // Word index is the byte address with the two lane bits shifted out; the
  // full shifted value is compared so out-of-range indices never alias.
  assign wr_word     = s_axi.s_axi_awaddr >> 2;
  assign rd_word     = s_axi.s_axi_araddr >> 2;
  assign wr_in_range = (wr_word < REG_COUNT);
  assign rd_in_range = (rd_word < REG_COUNT);

  // A write needs address and data together; neither channel is accepted
  // alone, so AW and W always complete in the same cycle.
  assign wr_cand  = s_axi.s_axi_awvalid & s_axi.s_axi_wvalid;
  assign rd_cand  = s_axi.s_axi_arvalid;
  assign grant_wr = ~rst & (state == IDLE) & wr_cand & (~rd_cand | ~last_grant_wr);
  assign grant_rd = ~rst & (state == IDLE) & rd_cand & (~wr_cand |  last_grant_wr);

  assign s_axi.s_axi_awready = grant_wr;
  assign s_axi.s_axi_wready  = grant_wr;
  assign s_axi.s_axi_arready = grant_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      last_grant_wr      <= 1'b0;
      s_axi.s_axi_bvalid <= 1'b0;
      s_axi.s_axi_bresp  <= RESP_OKAY;
      s_axi.s_axi_rvalid <= 1'b0;
      s_axi.s_axi_rresp  <= RESP_OKAY;
      s_axi.s_axi_rdata  <= '0;
      reg_wr_en          <= '0;
      reg_wr_data        <= '0;
      reg_wr_strb        <= '0;
    end else begin
      // The strobe lives only in the first WR_RESP cycle.
      reg_wr_en <= '0;
      case (state)
        IDLE: begin
          if (grant_wr) begin
            reg_wr_en          <= decode_onehot(wr_word);
            reg_wr_data        <= s_axi.s_axi_wdata;
            reg_wr_strb        <= s_axi.s_axi_wstrb;
            s_axi.s_axi_bresp  <= resp_code(wr_in_range);
            s_axi.s_axi_bvalid <= 1'b1;
            last_grant_wr      <= 1'b1;
            state              <= WR_RESP;
          end else if (grant_rd) begin
            s_axi.s_axi_rdata  <= select_reg(reg_rd_data, rd_word);
            s_axi.s_axi_rresp  <= resp_code(rd_in_range);
            s_axi.s_axi_rvalid <= 1'b1;
            last_grant_wr      <= 1'b0;
            state              <= RD_RESP;
          end
        end
        WR_RESP: begin
          if (s_axi.s_axi_bready) begin
            s_axi.s_axi_bvalid <= 1'b0;
            state              <= IDLE;
          end
        end
        RD_RESP: begin
          if (s_axi.s_axi_rready) begin
            s_axi.s_axi_rvalid <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
